dcache_responder: RTL and testbench

DCACHE_RESPONDER -- requirements
Module: dcache_responder

---
 rtl/dcache_responder_pkg.sv | 6 +
 rtl/dcache_line_array.sv | 31 +++
 rtl/dcache_responder.sv | 100 ++++++++++
 tb/tb_dcache_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dcache_responder_pkg.sv
// dcache_responder_pkg: CPU-wide opcode constants and the responder state encoding shared with the arbiter.
package dcache_responder_pkg;
   localparam logic [10:0] LDUR = 11'h7C2;
   localparam logic [10:0] STUR = 11'h7C0;
   typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} dcacheState;
endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: direct-mapped tag/valid/data storage with combinational read and synchronous write.
module dcache_line_array #(
   parameter int LINES = 8,
   parameter int TAG_W = 58
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [$clog2(LINES)-1:0] index,
   output logic                     lineValid,
   output logic [TAG_W-1:0]         lineTag,
   output logic [63:0]              lineData,
   input  logic                     we,
   input  logic [TAG_W-1:0]         wrTag,
   input  logic [63:0]              wrData
);
   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];
   logic [63:0]      data [LINES];
   assign lineValid = valid[index];
   assign lineTag   = tags[index];
   assign lineData  = data[index];
   always_ff @(posedge clk or posedge reset)
      if (reset) valid <= '0;
      else if (we) valid[index] <= 1'b1;
   // Tags and data stay unreset; only the valid bits decide hits.
   always_ff @(posedge clk)
      if (we) begin
         tags[index] <= wrTag;
         data[index] <= wrData;
      end
endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: write-through, no-write-allocate direct-mapped data cache serving one arbitrated request at a time.
module dcache_responder
   import dcache_responder_pkg::*;
#(
   parameter int          LINES   = 8,
   parameter logic [10:0] LDUR_OP = LDUR,
   parameter logic [10:0] STUR_OP = STUR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] opcode3,
   input  logic [63:0] address,
   input  logic [63:0] dataIn,
   input  logic        allowedAccess,
   output logic [63:0] dataOut,
   output logic        dataValid,
   output logic        respId,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack
);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 61 - IDX_W;

   dcacheState  state, nextState;
   logic [60:0] capAddr, lookAddr;
   logic        capId;
   logic        lineValid, hit, accept, isStore, memDone, we;
   logic [TAG_W-1:0] lineTag;
   logic [63:0] lineData;

   assign stall    = state != IDLE;
   assign isStore  = opcode3 == STUR_OP;
   assign accept   = !stall && (opcode3 == LDUR_OP || isStore);
   assign memDone  = mem_req && mem_ack;
   // Lookups use the live request in IDLE and the captured one while busy.
   assign lookAddr = stall ? capAddr : address[63:3];
   assign hit      = lineValid && lineTag == lookAddr[60:IDX_W];
   assign we       = (accept && isStore && hit) || (state == FILL && memDone);

   dcache_line_array #(.LINES(LINES), .TAG_W(TAG_W)) lineArray (
      .clk       (clk),
      .reset     (reset),
      .index     (lookAddr[IDX_W-1:0]),
      .lineValid (lineValid),
      .lineTag   (lineTag),
      .lineData  (lineData),
      .we        (we),
      .wrTag     (lookAddr[60:IDX_W]),
      .wrData    (state == FILL ? mem_rdata : dataIn)
   );

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= nextState;

   always_comb begin
      nextState = state;
      case (state)
         IDLE:  nextState = !accept ? IDLE : isStore ? WRITE : hit ? RESP : FILL;
         FILL:  nextState = memDone ? RESP : FILL;
         WRITE: nextState = memDone ? IDLE : WRITE;
         RESP:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (accept) begin
         capAddr <= address[63:3];
         capId   <= allowedAccess;
      end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         dataOut   <= '0;
         dataValid <= 1'b0;
         respId    <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         dataValid <= state == RESP;
         if (state == RESP) begin
            dataOut <= lineData;
            respId  <= capId;
         end
         if (accept && (isStore || !hit)) begin
            mem_req   <= 1'b1;
            mem_we    <= isStore;
            mem_addr  <= address & ~64'h7;
            mem_wdata <= dataIn;
         end else if (memDone) mem_req <= 1'b0;
      end
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: directed checks of hit/miss loads, write-through stores, reset abort and stall holding.
module tb_dcache_responder;
   logic        clk = 0;
   logic        reset;
   logic [10:0] opcode3;
   logic [63:0] address, dataIn, dataOut, mem_addr, mem_wdata, mem_rdata;
   logic        allowedAccess, dataValid, respId, stall, mem_req, mem_we, mem_ack;
   int total = 0, passed = 0;

   dcache_responder dut (
      .clk(clk), .reset(reset), .opcode3(opcode3), .address(address), .dataIn(dataIn),
      .allowedAccess(allowedAccess), .dataOut(dataOut), .dataValid(dataValid), .respId(respId),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic req(input logic [10:0] op, input logic [63:0] a, input logic [63:0] d, input logic id);
      opcode3 = op; address = a; dataIn = d; allowedAccess = id;
      @(negedge clk);
      opcode3 = 11'h000;
   endtask

   // Called at a negedge; acks after mem_req has been seen high for lat sampled cycles.
   task automatic serveMem(input int lat, input logic [63:0] rd);
      int n = 0;
      while (!mem_req && n < 20) begin @(negedge clk); n++; end
      chk("memReqSeen", mem_req, 1);
      repeat (lat - 1) @(negedge clk);
      chk("memReqHeld", mem_req, 1);
      mem_ack = 1; mem_rdata = rd;
      @(negedge clk);
      mem_ack = 0;
      chk("memReqDrop", mem_req, 0);
   endtask

   initial begin
      reset = 1; opcode3 = 0; address = 0; dataIn = 0; allowedAccess = 0; mem_ack = 0; mem_rdata = 0;
      repeat (2) @(negedge clk);
      chk("rstDataValid", dataValid, 0);
      chk("rstDataOut", dataOut, 0);
      chk("rstRespId", respId, 0);
      chk("rstStall", stall, 0);
      chk("rstMemReq", mem_req, 0);
      chk("rstMemWe", mem_we, 0);
      chk("rstMemAddr", mem_addr, 0);
      chk("rstMemWdata", mem_wdata, 0);
      reset = 0;
      // Cold load miss with 3-cycle memory latency
      req(dcache_responder_pkg::LDUR, 64'h505, 0, 1);
      chk("fillStall", stall, 1);
      chk("fillWe", mem_we, 0);
      chk("fillAddr", mem_addr, 64'h500);
      serveMem(3, 64'hAAAA);
      chk("fillNoValidYet", dataValid, 0);
      @(negedge clk);
      chk("fillValid", dataValid, 1);
      chk("fillData", dataOut, 64'hAAAA);
      chk("fillId", respId, 1);
      chk("fillStallLow", stall, 0);
      @(negedge clk);
      chk("validOneCycle", dataValid, 0);
      chk("dataOutHeld", dataOut, 64'hAAAA);
      // Load hit
      req(dcache_responder_pkg::LDUR, 64'h500, 0, 0);
      chk("hitNoMemReq", mem_req, 0);
      chk("hitNoValidEdge1", dataValid, 0);
      @(negedge clk);
      chk("hitValid", dataValid, 1);
      chk("hitData", dataOut, 64'hAAAA);
      chk("hitId", respId, 0);
      // Store hit, then load returns new data
      req(dcache_responder_pkg::STUR, 64'h500, 64'h1234, 0);
      chk("stWe", mem_we, 1);
      chk("stWdata", mem_wdata, 64'h1234);
      chk("stAddr", mem_addr, 64'h500);
      chk("stStall", stall, 1);
      serveMem(2, 0);
      chk("stStallDone", stall, 0);
      chk("stNoValid", dataValid, 0);
      req(dcache_responder_pkg::LDUR, 64'h500, 0, 1);
      chk("stHitNoReq", mem_req, 0);
      @(negedge clk);
      chk("stHitValid", dataValid, 1);
      chk("stHitData", dataOut, 64'h1234);
      // Store miss leaves line alone; load then misses
      req(dcache_responder_pkg::STUR, 64'h540, 64'hBEEF, 0);
      chk("smWe", mem_we, 1);
      chk("smAddr", mem_addr, 64'h540);
      chk("smWdata", mem_wdata, 64'hBEEF);
      serveMem(1, 0);
      req(dcache_responder_pkg::LDUR, 64'h540, 0, 0);
      chk("smLoadMiss", mem_req, 1);
      chk("smLoadWe", mem_we, 0);
      chk("smLoadAddr", mem_addr, 64'h540);
      serveMem(2, 64'h5555);
      @(negedge clk);
      chk("smLoadData", dataOut, 64'h5555);
      // Refill 0x500, then abort a fill of 0x508 with reset (ack coincident)
      req(dcache_responder_pkg::LDUR, 64'h500, 0, 0);
      serveMem(1, 64'h7777);
      @(negedge clk);
      chk("refillData", dataOut, 64'h7777);
      req(dcache_responder_pkg::LDUR, 64'h508, 0, 1);
      chk("abortReq", mem_req, 1);
      mem_ack = 1; mem_rdata = 64'hDEAD;
      reset = 1;
      #1;
      chk("abortMemReq", mem_req, 0);
      chk("abortStall", stall, 0);
      chk("abortDataOut", dataOut, 0);
      @(negedge clk);
      reset = 0; mem_ack = 0;
      @(negedge clk);
      chk("abortNoValid", dataValid, 0);
      chk("abortNoReq", mem_req, 0);
      req(dcache_responder_pkg::LDUR, 64'h500, 0, 0);
      chk("postRstMiss", mem_req, 1);
      serveMem(1, 64'h9999);
      @(negedge clk);
      chk("postRstData", dataOut, 64'h9999);
      // Request held through a store's stall is accepted exactly once
      req(dcache_responder_pkg::STUR, 64'h500, 64'h42, 0);
      opcode3 = dcache_responder_pkg::LDUR; address = 64'h500; allowedAccess = 1;
      chk("holdStall", stall, 1);
      serveMem(2, 0);
      chk("holdIdle", stall, 0);
      @(negedge clk);
      opcode3 = 11'h000;
      chk("holdAccepted", stall, 1);
      chk("holdHitNoReq", mem_req, 0);
      @(negedge clk);
      chk("holdValid", dataValid, 1);
      chk("holdData", dataOut, 64'h42);
      chk("holdId", respId, 1);
      @(negedge clk);
      chk("holdOnce", dataValid, 0);
      // NOP opcode in IDLE does nothing
      opcode3 = 11'h000; address = 64'h500;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("nopStall", stall, 0);
         chk("nopReq", mem_req, 0);
         chk("nopValid", dataValid, 0);
      end
      chk("nopDataHeld", dataOut, 64'h42);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
